instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage sitting directly upstream of the 128-byte instruction memory in simple_core. It owns the PC, drives the combinational read address into the memory, and captures the returned 32-bit word into an IF/ID output register. That register is handed to decode over a valid/ready handshake. It supports branch/jump redirect with flush, fetch enable/halt, and back-pressure from decode.

Parameters:
ADDR_W, 7, byte-address width of instruction memory (128 bytes)
INSTR_W, 32, instruction width
RESET_PC, 7'h00, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
fetch_en  in  1  1 = fetch permitted; 0 = halt new fetches
redirect_valid  in  1  taken branch/jump this cycle
redirect_pc  in  ADDR_W  redirect target byte address
imem_addr  out  ADDR_W  read address to instruction memory (combinational = pc)
imem_data  in  INSTR_W  read data from instruction memory (combinational, same cycle)
out_valid  out  1  IF/ID register holds a valid instruction
out_ready  in  1  decode accepts the instruction this cycle
out_instr  out  INSTR_W  fetched instruction
out_pc  out  ADDR_W  byte address of out_instr

Behaviour:
- Reset (rst=1 at an edge): pc<=RESET_PC; out_valid<=0; out_instr<=0; out_pc<=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr = pc, purely combinational. Memory read latency is 0 cycles, so fetch-to-out_valid latency is 1 cycle.
- Define load = !out_valid || out_ready (output register free or being drained).
- Priority at each edge is redirect > load > hold:
  - redirect_valid=1: pc<={redirect_pc[ADDR_W-1:2],2'b00} (low bits forced to 0). out_valid<=0, flushing the wrong-path instruction even if out_ready=0. No capture this cycle.
  - Else load && fetch_en: out_instr<=imem_data; out_pc<=pc; out_valid<=1; pc<=pc+4 modulo 2^ADDR_W (124 wraps to 0).
  - Else load && !fetch_en: out_valid<=0; pc, out_instr and out_pc hold.
  - Else (out_valid && !out_ready): stall; all state holds; imem_addr stable.
- Handshake: a transfer occurs when out_valid && out_ready at an edge. out_instr and out_pc must not change while out_valid=1 and out_ready=0, except that redirect may drop out_valid.
- out_ready is ignored when out_valid=0.
- pc is always word-aligned (pc[1:0]=0).
- No state machine beyond the valid bit. Two effective states: EMPTY (out_valid=0) and FULL (out_valid=1).

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined: adds output port misalign_trap (1 bit, registered, reset 0). It pulses high for exactly 1 cycle after a redirect with redirect_pc[1:0]!=0. On that redirect pc still loads the masked address, and the flush still happens.
- Undefined: port absent; misaligned targets are silently masked.

Decomposition:
- Package fetch_pkg holds:
  - constants ADDR_W=7, INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h00000013 (for bench use);
  - typedef pc_t (logic [ADDR_W-1:0]);
  - typedef instr_t (logic [INSTR_W-1:0]).
- One sub-module, fetch_pc_reg, holds the PC register, increment/wrap and redirect masking. instr_fetch holds the IF/ID register and handshake.

Test Plan:
1. Reset then free run: preload imem words 0x11111111@0, 0x22222222@4, 0x33333333@8; hold rst 2 cycles, then fetch_en=1, out_ready=1. Expect out_valid=0 during reset. First cycle after rst deasserts: out_valid=1, out_pc=0, out_instr=0x11111111. Next two cycles: out_pc=4/0x22222222, then out_pc=8/0x33333333.
2. Back-pressure: with out_valid=1, out_pc=4, drive out_ready=0 for 3 cycles. Expect out_instr/out_pc frozen and imem_addr=8 constant. Raise out_ready: next cycle out_pc=8.
3. Redirect flush during stall: out_valid=1, out_ready=0, redirect_valid=1, redirect_pc=0x40. Next cycle out_valid=0 and imem_addr=0x40. Following cycle out_pc=0x40.
4. Wrap-around: redirect to 0x7C, then run with out_ready=1. Expect out_pc sequence 0x7C, 0x00, 0x04.
5. Halt and reset mid-stall: set fetch_en=0 with out_ready=1. Expect out_valid=0 after the current word drains, and pc held. Then assert rst while out_valid=1, out_ready=0. Expect out_valid=0 and imem_addr=RESET_PC next cycle.
6. (FETCH_MISALIGN_TRAP_EN) Redirect with redirect_pc=0x22. Expect misalign_trap=1 for exactly 1 cycle and imem_addr=0x20. Redirect to 0x24: expect misalign_trap stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, constants and types for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W  = 7;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// PC register: reset load, word-aligned redirect, and +4 advance with natural wrap.
module fetch_pc_reg #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);
  import fetch_pkg::*;

  // Low two bits are forced to zero so the PC can never become misaligned.
  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (advance)        pc <= pc + ADDR_W'(PC_STEP);
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives imem_addr from the PC and holds the IF/ID register behind a valid/ready handshake.
// Optional FETCH_MISALIGN_TRAP_EN adds a registered misalign_trap pulse for unaligned redirect targets.
module instr_fetch #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic               misalign_trap,
`endif
  output logic [ADDR_W-1:0]  out_pc
);
  logic              load;
  logic              capture;
  logic [ADDR_W-1:0] pc;

  assign load      = !out_valid || out_ready;
  assign capture   = !redirect_valid && load && fetch_en;
  assign imem_addr = pc;

  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (capture),
    .pc             (pc)
  );

  // Redirect flushes even a stalled word; a halted-but-free register just goes empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= fetch_en;
      if (fetch_en) begin
        out_instr <= imem_data;
        out_pc    <= pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_trap <= 1'b0;
    else     misalign_trap <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational 32-word instruction memory model.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, out_ready, out_valid;
  logic [6:0]  redirect_pc, imem_addr, out_pc;
  logic [31:0] imem_data, out_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif
  logic [31:0] mem [0:31];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap),
`endif
    .out_pc(out_pc)
  );

  assign imem_data = mem[imem_addr[6:2]];

  function automatic logic [31:0] word_at(input logic [6:0] a);
    case (a)
      7'h00:   return 32'h11111111;
      7'h04:   return 32'h22222222;
      7'h08:   return 32'h33333333;
      default: return 32'hA5000000 | {25'd0, a};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [6:0] pc_e,
                            input logic [6:0] addr_e);
    checks++;
    if (out_valid !== v || (v && (out_pc !== pc_e || out_instr !== word_at(pc_e))) ||
        imem_addr !== addr_e) begin
      failures++;
      $display("FAIL %s: got valid=%0b pc=%h instr=%h addr=%h, want valid=%0b pc=%h instr=%h addr=%h",
               name, out_valid, out_pc, out_instr, imem_addr, v, pc_e, word_at(pc_e), addr_e);
    end
  endtask

  task automatic test_reset();
    rst = 1; fetch_en = 1; out_ready = 1; redirect_valid = 0; redirect_pc = '0;
    step();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 7'h00) begin
      failures++; $display("FAIL reset1: valid=%0b addr=%h, want 0/00", out_valid, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 7'h00 || out_instr !== 32'h0) begin
      failures++; $display("FAIL reset2: valid=%0b pc=%h instr=%h, want 0/00/0", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_free_run();
    rst = 0;
    step(); expect_out("run0", 1, 7'h00, 7'h04);
    step(); expect_out("run1", 1, 7'h04, 7'h08);
    step(); expect_out("run2", 1, 7'h08, 7'h0C);
  endtask

  task automatic test_back_pressure();
    redirect_valid = 1; redirect_pc = 7'h04;
    step(); redirect_valid = 0;
    expect_out("bp_redir", 0, 7'h00, 7'h04);
    step(); expect_out("bp_fill", 1, 7'h04, 7'h08);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("bp_stall", 1, 7'h04, 7'h08);
    end
    out_ready = 1;
    step(); expect_out("bp_release", 1, 7'h08, 7'h0C);
  endtask

  task automatic test_redirect_flush();
    out_ready = 0;
    step(); expect_out("fl_stall", 1, 7'h08, 7'h0C);
    redirect_valid = 1; redirect_pc = 7'h40;
    step(); redirect_valid = 0;
    expect_out("fl_flush", 0, 7'h00, 7'h40);
    step(); expect_out("fl_refill", 1, 7'h40, 7'h44);
    out_ready = 1;
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 7'h7C;
    step(); redirect_valid = 0;
    expect_out("wr_redir", 0, 7'h00, 7'h7C);
    step(); expect_out("wr_7c", 1, 7'h7C, 7'h00);
    step(); expect_out("wr_00", 1, 7'h00, 7'h04);
    step(); expect_out("wr_04", 1, 7'h04, 7'h08);
  endtask

  task automatic test_halt_reset();
    fetch_en = 0;
    step(); expect_out("halt_drain", 0, 7'h00, 7'h08);
    step(); expect_out("halt_hold", 0, 7'h00, 7'h08);
    checks++;
    if (out_pc !== 7'h04 || out_instr !== 32'h22222222) begin
      failures++; $display("FAIL halt_regs: pc=%h instr=%h, want 04/22222222", out_pc, out_instr);
    end
    fetch_en = 1;
    step(); expect_out("halt_resume", 1, 7'h08, 7'h0C);
    out_ready = 0;
    step(); expect_out("rst_stall", 1, 7'h08, 7'h0C);
    rst = 1;
    step();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 7'h00 || out_pc !== 7'h00 || out_instr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_stall: valid=%0b addr=%h pc=%h instr=%h, want 0/00/00/0",
               out_valid, imem_addr, out_pc, out_instr);
    end
    rst = 0; out_ready = 1;
    step(); expect_out("rst_restart", 1, 7'h00, 7'h04);
  endtask

  task automatic test_misalign();
    redirect_valid = 1; redirect_pc = 7'h22;
    step(); redirect_valid = 0;
    expect_out("mis_mask", 0, 7'h00, 7'h20);
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (misalign_trap !== 1'b1) begin
      failures++; $display("FAIL trap_set: got %0b want 1", misalign_trap);
    end
`endif
    step(); expect_out("mis_fill", 1, 7'h20, 7'h24);
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (misalign_trap !== 1'b0) begin
      failures++; $display("FAIL trap_pulse: got %0b want 0", misalign_trap);
    end
`endif
    redirect_valid = 1; redirect_pc = 7'h24;
    step(); redirect_valid = 0;
    expect_out("al_redir", 0, 7'h00, 7'h24);
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (misalign_trap !== 1'b0) begin
      failures++; $display("FAIL trap_aligned: got %0b want 0", misalign_trap);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = word_at(7'(i * 4));
    test_reset();
    test_free_run();
    test_back_pressure();
    test_redirect_flush();
    test_wrap();
    test_halt_reset();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
